// File: rtl/cache_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : cache_ctrl_pkg
// Brief  : Shared types and default widths for the cache controller slice.
//          Holds the controller state encoding and the default address,
//          data and statistics-counter widths.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_ctrl_pkg;

  localparam int c_ADDR_W = 15;  // request / datapath word address width
  localparam int c_DATA_W = 32;  // data word width
  localparam int c_CNT_W  = 13;  // statistics counter width (datapath hitCount)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MEM   = 3'd2,
    ST_FILL  = 3'd3,
    ST_READ  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cache_controller_if.sv
//------------------------------------------------------------------------------
// Module : cache_controller_if
// Brief  : Request / response channel between a requester and the cache
//          controller.
//          Request : reqValid, reqReady, reqAddr
//          Response: respValid, respReady, respData, respHit
//          master = requester side, slave = controller side.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cache_controller_if
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
);

  logic              reqValid;
  logic              reqReady;
  logic [ADDR_W-1:0] reqAddr;
  logic              respValid;
  logic              respReady;
  logic [DATA_W-1:0] respData;
  logic              respHit;

  modport master (
    output reqValid, reqAddr, respReady,
    input  reqReady, respValid, respData, respHit
  );

  modport slave (
    input  reqValid, reqAddr, respReady,
    output reqReady, respValid, respData, respHit
  );

endinterface

`default_nettype wire

// File: rtl/mem_wait_timer.sv
//------------------------------------------------------------------------------
// Module : mem_wait_timer
// Brief  : Loadable down-counter timing the memory-read dwell.
//          load : load the counter with MEM_LAT-1
//          dec  : decrement by one (stops at zero)
//          zero : counter currently equals zero
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_LAT = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic load,
  input  wire logic dec,
  output logic      zero
);

  localparam int          c_TW   = $clog2(MEM_LAT) + 1;
  localparam logic [c_TW-1:0] c_LOAD = c_TW'(MEM_LAT - 1);

  logic [c_TW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_LOAD;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - c_TW'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
//------------------------------------------------------------------------------
// Module : cache_controller
// Brief  : Control stage in front of the direct-mapped cache datapath.
//          Accepts one read at a time, sequences the datapath strobes through
//          the hit path (CHECK->READ) or the miss path (CHECK->MEM->FILL->READ)
//          and returns the word on the response channel. Keeps access and
//          miss counts.
// Ports  : clk, rst_n         clock, async active-low reset
//          bus (slave)        request/response channel
//          address            latched request address to datapath
//          checkHit, readMem, writeCache, readCache, hitCountEn
//                             datapath strobes
//          hit, dataOut       datapath tag result / read word
//          accessCount        accepted requests (wraps)
//          missCount          misses (wraps)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = c_ADDR_W,
  parameter int DATA_W  = c_DATA_W,
  parameter int CNT_W   = c_CNT_W,
  parameter int MEM_LAT = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  cache_controller_if.slave bus,
  output logic [ADDR_W-1:0] address,
  output logic              checkHit,
  output logic              readCache,
  output logic              writeCache,
  output logic              readMem,
  output logic              hitCountEn,
  input  wire logic         hit,
  input  wire logic [DATA_W-1:0] dataOut,
  output logic [CNT_W-1:0]  accessCount,
  output logic [CNT_W-1:0]  missCount
);

  state_t r_state;
  state_t w_next;
  logic   w_timer_zero;
  logic   w_accept;
  logic   w_miss;

  assign w_accept = (r_state == ST_IDLE) && bus.reqValid;
  assign w_miss   = (r_state == ST_CHECK) && !hit;

  // The timer is armed on the CHECK->MEM transition so that MEM dwells
  // exactly MEM_LAT cycles: it leaves MEM in the cycle the count is zero.
  mem_wait_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_miss),
    .dec   (r_state == ST_MEM),
    .zero  (w_timer_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.reqValid)  w_next = ST_CHECK;
      ST_CHECK: w_next = hit ? ST_READ : ST_MEM;
      ST_MEM:   if (w_timer_zero)  w_next = ST_FILL;
      ST_FILL:  w_next = ST_READ;
      ST_READ:  w_next = ST_DONE;
      ST_DONE:  if (bus.respReady) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output decode: Moore strobes, except hitCountEn which follows hit in CHECK
  always_comb begin
    bus.reqReady  = (r_state == ST_IDLE);
    bus.respValid = (r_state == ST_DONE);
    checkHit      = (r_state == ST_CHECK);
    hitCountEn    = (r_state == ST_CHECK) && hit;
    readMem       = (r_state == ST_MEM);
    writeCache    = (r_state == ST_FILL);
    readCache     = (r_state == ST_READ);
  end

  // Address latch, response register and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address      <= '0;
      bus.respData <= '0;
      bus.respHit  <= 1'b0;
      accessCount  <= '0;
      missCount    <= '0;
    end else begin
      if (w_accept) begin
        address     <= bus.reqAddr;
        accessCount <= accessCount + CNT_W'(1);
      end
      if (r_state == ST_CHECK) begin
        bus.respHit <= hit;
      end
      if (w_miss) begin
        missCount <= missCount + CNT_W'(1);
      end
      if (r_state == ST_READ) begin
        bus.respData <= dataOut;
      end
    end
  end

endmodule

`default_nettype wire
